// File: rtl/reduce_gate_seq.sv
// Multi-channel sequential AND/OR/XOR reduction (optionally inverted), CHUNK_WIDTH bits per cycle.
// Optional feature: define REDUCE_EARLY_EXIT_EN to finish as soon as every accumulator is absorbed.
module reduce_gate_seq #(
  parameter int INPUT_WIDTH = 8,
  parameter int CHUNK_WIDTH = 3,
  parameter int CHANNELS    = 2
) (
  input  logic                            clock,
  input  logic                            resetN,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic [CHANNELS*INPUT_WIDTH-1:0] inData,
  input  logic [1:0]                      opMode,
  input  logic                            opInvert,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [CHANNELS-1:0]             outData,
  output logic                            busy
);

  localparam int NUM_CHUNKS = (INPUT_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int CNT_W      = $clog2(NUM_CHUNKS) + 1;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                            state_r;
  logic [CNT_W-1:0]                  cnt_r;
  logic [CHANNELS-1:0][PAD_W-1:0]    data_r;
  logic [1:0]                        op_r;
  logic                              inv_r;
  logic [CHANNELS-1:0]               acc_r;
  logic                              out_valid_r;
  logic [CHANNELS-1:0]               out_data_r;

  logic                              in_ready_s;
  logic                              accept_s;
  logic                              id_in_s;
  logic [CHANNELS-1:0][PAD_W-1:0]    load_s;
  logic [CHANNELS-1:0]               acc_next_s;
  logic                              last_s;
  logic                              finish_s;

  // Identity element: 1 for AND, 0 for OR and both XOR encodings.
  function automatic logic op_identity(input logic [1:0] op);
    return (op == 2'b00);
  endfunction

  // Fold one chunk into a single-bit accumulator.
  function automatic logic fold_chunk(input logic acc, input logic [CHUNK_WIDTH-1:0] chunk,
                                      input logic [1:0] op);
    logic res;
    case (op)
      2'b00:   res = acc & (&chunk);
      2'b01:   res = acc | (|chunk);
      default: res = acc ^ (^chunk);
    endcase
    return res;
  endfunction

  assign in_ready_s = (state_r == IDLE) | ((state_r == DONE) & outReady);
  assign accept_s   = inValid & in_ready_s;
  assign id_in_s    = op_identity(opMode);
  assign last_s     = (cnt_r == LAST_CHUNK);

  // Pad each incoming word up to a whole number of chunks with the identity bit.
  always_comb begin
    load_s = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      load_s[ch]                    = {PAD_W{id_in_s}};
      load_s[ch][INPUT_WIDTH-1:0]   = inData[ch*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  // Next accumulator values: the current low chunk folded into each channel.
  always_comb begin
    acc_next_s = acc_r;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      acc_next_s[ch] = fold_chunk(acc_r[ch], data_r[ch][CHUNK_WIDTH-1:0], op_r);
    end
  end

`ifdef REDUCE_EARLY_EXIT_EN
  logic absorb_s;

  // Absorbed once every channel sits at the value no further chunk can change.
  always_comb begin
    absorb_s = 1'b0;
    case (op_r)
      2'b00:   absorb_s = ~(|acc_next_s);
      2'b01:   absorb_s = &acc_next_s;
      default: absorb_s = 1'b0;
    endcase
  end

  assign finish_s = last_s | absorb_s;
`else
  assign finish_s = last_s;
`endif

  // Control FSM with registered result and data path state.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      data_r      <= '0;
      op_r        <= 2'b00;
      inv_r       <= 1'b0;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (accept_s) begin
      state_r     <= RUN;
      cnt_r       <= '0;
      data_r      <= load_s;
      op_r        <= opMode;
      inv_r       <= opInvert;
      acc_r       <= {CHANNELS{id_in_s}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          for (int ch = 0; ch < CHANNELS; ch++) begin
            data_r[ch] <= data_r[ch] >> CHUNK_WIDTH;
          end
          if (finish_s) begin
            out_data_r  <= acc_next_s ^ {CHANNELS{inv_r}};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (outReady) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign inReady  = in_ready_s;
  assign outValid = out_valid_r;
  assign outData  = out_data_r;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_reduce_gate_seq.sv
// Directed self-checking bench for reduce_gate_seq with a queue scoreboard of expected results.
module tb_reduce_gate_seq;

  localparam int IW = 8;
  localparam int CH = 2;

  logic          clock    = 1'b0;
  logic          resetN   = 1'b0;
  logic          inValid  = 1'b0;
  logic          outReady = 1'b0;
  logic          opInvert = 1'b0;
  logic [15:0]   inData   = 16'h0000;
  logic [1:0]    opMode   = 2'b00;
  logic          inReady;
  logic          outValid;
  logic          busy;
  logic [1:0]    outData;

  int            checks = 0;
  int            errors = 0;
  logic [1:0]    exp_q[$];
  logic [1:0]    held;
  int            early_lat;

  reduce_gate_seq #(.INPUT_WIDTH(8), .CHUNK_WIDTH(3), .CHANNELS(2)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .inData(inData), .opMode(opMode), .opInvert(opInvert), .outValid(outValid),
    .outReady(outReady), .outData(outData), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model(input logic [15:0] d, input logic [1:0] m, input logic inv);
    logic [1:0] r;
    logic [7:0] w;
    r = 2'b00;
    for (int k = 0; k < CH; k++) begin
      w = d[k*IW +: IW];
      case (m)
        2'b00:   r[k] = &w;
        2'b01:   r[k] = |w;
        default: r[k] = ^w;
      endcase
      r[k] = r[k] ^ inv;
    end
    return r;
  endfunction

  // Call just after a negedge: presents a word, lets it be accepted, then scrambles inputs.
  task automatic drive_accept(input string tag, input logic [15:0] d, input logic [1:0] m,
                              input logic inv);
    inData = d; opMode = m; opInvert = inv; inValid = 1'b1;
    #1;
    check({tag, " inReady"}, inReady, 1'b1);
    exp_q.push_back(model(d, m, inv));
    @(posedge clock);
    #1;
    inValid  = 1'b0;
    inData   = 16'($urandom);
    opMode   = 2'($urandom);
    opInvert = 1'($urandom);
  endtask

  task automatic wait_result(input string tag, input int lat);
    int n;
    logic [1:0] e;
    n = 0;
    while (outValid !== 1'b1 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, " latency"}, n, lat);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected result queued", tag);
    end else begin
      e = exp_q.pop_front();
      held = e;
      check({tag, " outData"}, outData, e);
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clock);
    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    check({tag, " outValid drop"}, outValid, 1'b0);
    check({tag, " idle busy"}, busy, 1'b0);
    check({tag, " idle inReady"}, inReady, 1'b1);
  endtask

  initial begin
`ifdef REDUCE_EARLY_EXIT_EN
    early_lat = 1;
`else
    early_lat = 3;
`endif
    #2;
    check("reset inReady", inReady, 1'b1);
    check("reset outValid", outValid, 1'b0);
    check("reset outData", outData, 2'b00);
    check("reset busy", busy, 1'b0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);

    drive_accept("and_pad", {8'hFF, 8'hFE}, 2'b00, 1'b0);
    check("and_pad busy", busy, 1'b1);
    wait_result("and_pad", 3);
    release_result("and_pad");

    @(negedge clock);
    drive_accept("nand", {8'hFF, 8'h00}, 2'b00, 1'b1);
    wait_result("nand", 3);
    release_result("nand");
    @(negedge clock);
    drive_accept("nor", {8'hFF, 8'h00}, 2'b01, 1'b1);
    wait_result("nor", 3);
    release_result("nor");

    @(negedge clock);
    drive_accept("xor", {8'h07, 8'h80}, 2'b10, 1'b0);
    wait_result("xor", 3);
    release_result("xor");
    @(negedge clock);
    drive_accept("xnor", {8'h07, 8'h80}, 2'b10, 1'b1);
    wait_result("xnor", 3);
    release_result("xnor");
    @(negedge clock);
    drive_accept("xor_alias", {8'h03, 8'h7F}, 2'b11, 1'b0);
    wait_result("xor_alias", 3);
    release_result("xor_alias");

    // Backpressure then back-to-back accept in DONE.
    @(negedge clock);
    drive_accept("bp_first", {8'h80, 8'h00}, 2'b01, 1'b0);
    wait_result("bp_first", 3);
    repeat (5) begin
      @(negedge clock);
      check("bp outValid held", outValid, 1'b1);
      check("bp outData held", outData, held);
      check("bp inReady low", inReady, 1'b0);
    end
    outReady = 1'b1;
    drive_accept("bp_next", {8'hF0, 8'h0F}, 2'b10, 1'b1);
    outReady = 1'b0;
    check("bp outValid drop", outValid, 1'b0);
    check("bp busy run", busy, 1'b1);
    wait_result("bp_next", 3);
    release_result("bp_next");

    // Reset in the middle of RUN.
    @(negedge clock);
    drive_accept("rst_run", {8'hFF, 8'hFF}, 2'b00, 1'b0);
    @(posedge clock);
    #1;
    resetN = 1'b0;
    #1;
    check("rst outValid", outValid, 1'b0);
    check("rst outData", outData, 2'b00);
    check("rst inReady", inReady, 1'b1);
    check("rst busy", busy, 1'b0);
    exp_q.delete();
    repeat (3) begin
      @(posedge clock);
      #1;
      check("rst no outValid", outValid, 1'b0);
    end
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    drive_accept("post_rst", {8'hFF, 8'h7F}, 2'b00, 1'b0);
    wait_result("post_rst", 3);
    release_result("post_rst");

    @(negedge clock);
    drive_accept("early_and", {8'h00, 8'h01}, 2'b00, 1'b0);
    wait_result("early_and", early_lat);
    release_result("early_and");
    @(negedge clock);
    drive_accept("early_xor", {8'h00, 8'h01}, 2'b10, 1'b0);
    wait_result("early_xor", 3);
    release_result("early_xor");

    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive_accept("rand_xor", 16'($urandom), {1'b1, 1'($urandom)}, 1'($urandom));
      wait_result("rand_xor", 3);
      release_result("rand_xor");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
